clk_div_even: RTL and testbench

//  - Divides the 100 MHz board clock by an even integer ratio to produce the VGA pixel clock (25 MHz at DIV=4).
//  - Produces a 50% duty divided clock, plus a one-cycle enable strobe in the source domain.
//  - Sits at the front of the video pipeline. The timing generator uses the strobe as a clock enable; the divided clock is exported for legacy logic.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_even_if.sv | 26 ++
 rtl/clk_div_phase_ctr.sv | 36 +++
 rtl/clk_div_even.sv | 98 +++++++++
 tb/tb_clk_div_even.sv | 109 ++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared helpers for the even clock divider: ratio legality, phase width and default phase decodes.
// Build option: define CLKDIV_LOCK_EN to count output periods before asserting locked.
package clk_div_pkg;

  localparam int DEFAULT_DIV_RATIO = 4;
  localparam int HALF_LAST         = DEFAULT_DIV_RATIO / 2 - 1;
  localparam int FULL_LAST         = DEFAULT_DIV_RATIO - 1;

  function automatic bit div_ratio_ok(input int div);
    return (div >= 2) && ((div % 2) == 0);
  endfunction

  // A ratio of 2 still needs one bit of phase.
  function automatic int phase_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/clk_div_even_if.sv
// Divider output bundle: divided clock, source-domain strobe, phase and lock status.
// Build option: CLKDIV_LOCK_EN changes only how locked is produced, not this bundle.
interface clk_div_even_if #(
  parameter int CNT_W = 2
);

  logic             clk25MHz;
  logic             clk_en;
  logic [CNT_W-1:0] phase;
  logic             locked;

  modport master (
    output clk25MHz,
    output clk_en,
    output phase,
    output locked
  );

  modport slave (
    input clk25MHz,
    input clk_en,
    input phase,
    input locked
  );

endinterface

// File: rtl/clk_div_phase_ctr.sv
// Modulo-(LAST+1) phase counter with registered count and decodes for the terminal and mid-period phases.
// Build option: CLKDIV_LOCK_EN does not affect this block.
module clk_div_phase_ctr
  import clk_div_pkg::*;
#(
  parameter int CNT_W = phase_width(DEFAULT_DIV_RATIO),
  parameter int LAST  = FULL_LAST,
  parameter int MID   = HALF_LAST
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o,
  output logic             mid_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tc_o  = (cnt_q == CNT_W'(LAST));
    mid_o = (cnt_q == CNT_W'(MID));
    cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/clk_div_even.sv
// Even-ratio clock divider: 50% duty registered divided clock plus a cycle-aligned enable strobe.
// Build option: define CLKDIV_LOCK_EN to hold locked low until LOCK_PERIODS strobes have been seen.
module clk_div_even
  import clk_div_pkg::*;
#(
  parameter  int DIV_RATIO    = DEFAULT_DIV_RATIO,
  parameter  int LOCK_PERIODS = 2,
  localparam int CNT_W        = phase_width(DIV_RATIO)
) (
  input  logic           clk100Mhz,
  input  logic           rst,
  clk_div_even_if.master bus
);

  if (!div_ratio_ok(DIV_RATIO)) begin : g_bad_ratio
    $error("clk_div_even: DIV_RATIO must be even and >= 2");
  end
  if (LOCK_PERIODS < 1) begin : g_bad_lock
    $error("clk_div_even: LOCK_PERIODS must be >= 1");
  end

  logic [CNT_W-1:0] phase;
  logic             tc;
  logic             mid;
  logic             duty_q, duty_d;
  logic             en_q;
  logic             locked_q, locked_d;

  clk_div_phase_ctr #(
    .CNT_W (CNT_W),
    .LAST  (DIV_RATIO - 1),
    .MID   (DIV_RATIO / 2 - 1)
  ) u_phase_ctr (
    .clk_i (clk100Mhz),
    .rst_i (rst),
    .cnt_o (phase),
    .tc_o  (tc),
    .mid_o (mid)
  );

  // Rise at the terminal phase, fall at the mid phase; both are distinct even for a ratio of 2.
  always_comb begin
    duty_d = duty_q;
    if (tc) begin
      duty_d = 1'b1;
    end else if (mid) begin
      duty_d = 1'b0;
    end
  end

`ifdef CLKDIV_LOCK_EN
  localparam int LOCK_W = $clog2(LOCK_PERIODS + 1);

  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

  // Saturating strobe count; locked sets on the edge registering the final required strobe.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (tc && (lock_cnt_q != LOCK_W'(LOCK_PERIODS))) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end
    if (tc && (lock_cnt_q == LOCK_W'(LOCK_PERIODS - 1))) begin
      locked_d = 1'b1;
    end
  end

  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  always_comb begin
    locked_d = 1'b1;
  end
`endif

  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      duty_q   <= 1'b0;
      en_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      duty_q   <= duty_d;
      en_q     <= tc;
      locked_q <= locked_d;
    end
  end

  assign bus.clk25MHz = duty_q;
  assign bus.clk_en   = en_q;
  assign bus.phase    = phase;
  assign bus.locked   = locked_q;

endmodule

// File: tb/tb_clk_div_even.sv
// Directed self-checking bench for clk_div_even at DIV_RATIO=4 and DIV_RATIO=2 side by side.
// Lock expectations follow whether CLKDIV_LOCK_EN is defined for the build.
module tb_clk_div_even;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic prevClkA = 1'b0, prevEnA = 1'b0;
  logic prevClkB = 1'b0, prevEnB = 1'b0;

  always #5 clk = ~clk;

  clk_div_even_if #(.CNT_W(2)) busA ();
  clk_div_even_if #(.CNT_W(1)) busB ();

  clk_div_even #(.DIV_RATIO(4), .LOCK_PERIODS(2)) dutA (
    .clk100Mhz (clk),
    .rst       (rst),
    .bus       (busA.master)
  );

  clk_div_even #(.DIV_RATIO(2), .LOCK_PERIODS(2)) dutB (
    .clk100Mhz (clk),
    .rst       (rst),
    .bus       (busB.master)
  );

  task automatic checkOutput(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s edge=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " A.phase"},  0, 32'(busA.phase), 0);
    checkOutput({tag, " A.clk"},    0, 32'(busA.clk25MHz), 0);
    checkOutput({tag, " A.en"},     0, 32'(busA.clk_en), 0);
    checkOutput({tag, " A.locked"}, 0, 32'(busA.locked), 0);
    checkOutput({tag, " B.phase"},  0, 32'(busB.phase), 0);
    checkOutput({tag, " B.clk"},    0, 32'(busB.clk25MHz), 0);
    checkOutput({tag, " B.en"},     0, 32'(busB.clk_en), 0);
    checkOutput({tag, " B.locked"}, 0, 32'(busB.locked), 0);
    prevClkA = 1'b0; prevEnA = 1'b0;
    prevClkB = 1'b0; prevEnB = 1'b0;
  endtask

  // Edge k counts rising edges since rst was released; expected values are the hand-derived waveforms.
  task automatic applyStimulus(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      logic expClkA, expEnA, expLockA, expClkB, expEnB, expLockB;
      @(posedge clk);
      #1;
      expClkA = (k >= 4) && ((k % 4) <= 1);
      expEnA  = (k >= 4) && ((k % 4) == 0);
      expClkB = (k >= 2) && ((k % 2) == 0);
      expEnB  = expClkB;
`ifdef CLKDIV_LOCK_EN
      expLockA = (k >= 8);
      expLockB = (k >= 4);
`else
      expLockA = (k >= 1);
      expLockB = (k >= 1);
`endif
      checkOutput("A.phase",  k, 32'(busA.phase), k % 4);
      checkOutput("A.clk",    k, 32'(busA.clk25MHz), 32'(expClkA));
      checkOutput("A.en",     k, 32'(busA.clk_en), 32'(expEnA));
      checkOutput("A.locked", k, 32'(busA.locked), 32'(expLockA));
      checkOutput("A.en_at_rise", k, 32'(busA.clk_en), 32'(busA.clk25MHz & ~prevClkA));
      checkOutput("A.en_single",  k, 32'(busA.clk_en & prevEnA), 0);
      checkOutput("B.phase",  k, 32'(busB.phase), k % 2);
      checkOutput("B.clk",    k, 32'(busB.clk25MHz), 32'(expClkB));
      checkOutput("B.en",     k, 32'(busB.clk_en), 32'(expEnB));
      checkOutput("B.locked", k, 32'(busB.locked), 32'(expLockB));
      checkOutput("B.en_at_rise", k, 32'(busB.clk_en), 32'(busB.clk25MHz & ~prevClkB));
      prevClkA = busA.clk25MHz; prevEnA = busA.clk_en;
      prevClkB = busB.clk25MHz; prevEnB = busB.clk_en;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkReset("hold");
    end

    rst = 1'b0;
    applyStimulus(1, 32);
    applyStimulus(33, 34);
    checkOutput("A.phase_before_rst", 34, 32'(busA.phase), 2);

    rst = 1'b1;
    @(posedge clk);
    #1;
    checkReset("mid_rst");

    rst = 1'b0;
    applyStimulus(1, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
